fetch_queue: RTL and testbench

Instruction prefetch queue between the instruction-fetch stage and the instruction-decode stage of the 5-stage RV32 pipeline. Buffers fetched (pc, instr) pairs in a small circular FIFO, decoupling fetch from decode stalls with a valid/ready handshake on both sides. A branch or jump redirect from the execute stage flushes all buffered entries. When empty, decode receives a NOP.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: datapath width,
// the canonical NOP and the (pc, instr) entry carried by the queue and the IF/ID register.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a DEPTH-entry circular FIFO of
// (pc, instr) pairs with valid/ready on both sides, flushed by execute-stage redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_instr,
    output logic                    out_misaligned,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two in 2..16");
    end

    fetch_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_push;
    logic                   w_pop;
    fetch_entry_t           w_head;

    // Handshakes are decided from the registered count only, so out_ready never reaches in_ready.
    assign in_ready  = (r_count != FULL_COUNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_head = r_mem[r_rd_ptr];

    // NOTE: the entry array has no reset; stale contents are never visible because
    // out_* are gated by count, and leaving it unreset keeps it as plain storage.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // NOTE: state registers use non-blocking assignment so every reader sees the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // NOTE: every output is given a default before the conditional so no latch is inferred.
    always_comb begin
        out_pc         = '0;
        out_instr      = NOP_INSTR;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = w_head.pc;
            out_instr      = w_head.instr;
            out_misaligned = (w_head.pc[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_instr;
    logic              out_misaligned;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misaligned (out_misaligned),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    fetch_entry_t     model_q[$];
    logic [XLEN-1:0]  delivered[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue updated from the handshake rules at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            bit do_push, do_pop;
            do_push = in_valid && (model_q.size() != DEPTH);
            do_pop  = out_ready && (model_q.size() != 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    // Compare all outputs against the model every cycle, then log real deliveries.
    always @(negedge clk) begin
        if (cmp_en) begin
            int sz;
            sz = model_q.size();
            check("count", 64'(count), 64'(sz));
            check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            check("out_pc", 64'(out_pc), (sz != 0) ? 64'(model_q[0].pc) : 64'h0);
            check("out_instr", 64'(out_instr), (sz != 0) ? 64'(model_q[0].instr) : 64'h13);
            check("out_misaligned", 64'(out_misaligned),
                  (sz != 0) ? 64'(model_q[0].pc[1:0] != 2'b00) : 64'h0);
        end
        #2;
        if (reset && !flush && out_valid && out_ready) delivered.push_back(out_pc);
    end

    // Apply inputs for one rising edge and return at the following falling edge.
    task automatic cycle(input logic v, input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc ^ 32'hA5A5_0000;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Reset and empty
        idle();
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst out_instr", 64'(out_instr), 64'h13);
        check("rst count", 64'(count), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'h1);

        // Fill and drain, with a refused fifth push
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
        check("full count", 64'(count), 64'h4);
        check("full in_ready", 64'(in_ready), 64'h0);
        check("model full", 64'(model_q.size()), 64'h4);
        delivered.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drain out_valid", 64'(out_valid), 64'h0);
        check("drain n", 64'(delivered.size()), 64'h4);
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            check("drain order", 64'(delivered[i]), 64'(4 * i));

        // Streaming across the pointer wrap
        delivered.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
            check("stream count", 64'(count), 64'h1);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("stream n", 64'(delivered.size()), 64'd10);
        for (int i = 0; i < 10 && i < delivered.size(); i++)
            check("stream order", 64'(delivered[i]), 64'h1000 + 64'(4 * i));

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0);
        delivered.delete();
        cycle(1'b1, 32'h40, 1'b1, 1'b1);
        check("flush count", 64'(count), 64'h0);
        check("flush out_valid", 64'(out_valid), 64'h0);
        check("flush in_ready", 64'(in_ready), 64'h1);
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        check("post-flush head", 64'(out_pc), 64'h100);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("post-flush n", 64'(delivered.size()), 64'h1);
        if (delivered.size() > 0) check("post-flush pc", 64'(delivered[0]), 64'h100);

        // Misaligned tag
        cycle(1'b1, 32'h102, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0);
        check("mis head pc", 64'(out_pc), 64'h102);
        check("mis 0x102", 64'(out_misaligned), 64'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("mis 0x104", 64'(out_misaligned), 64'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Async reset between edges with two entries queued
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 1'b0, 1'b0);
        in_valid = 1'b0;
        delivered.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_q.delete();
        #1;
        check("arst count", 64'(count), 64'h0);
        check("arst out_valid", 64'(out_valid), 64'h0);
        check("arst in_ready", 64'(in_ready), 64'h1);
        check("arst out_pc", 64'(out_pc), 64'h0);
        check("arst out_instr", 64'(out_instr), 64'h13);
        check("arst misaligned", 64'(out_misaligned), 64'h0);
        #1;
        reset = 1'b1;
        @(negedge clk);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("arst n", 64'(delivered.size()), 64'h1);
        if (delivered.size() > 0) check("arst pc", 64'(delivered[0]), 64'h200);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [XLEN-1:0] pc;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            cycle($urandom_range(0, 9) < 7, pc, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("final empty", 64'(out_valid), 64'h0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
